// File: rtl/pmem_responder_if.sv
// rtl/pmem_responder_if.sv - request/response channel between memory initiator and responder
interface pmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - single-outstanding word-array memory responder with fixed access latency
module pmem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h80000000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1
) (
  input  logic             clk,
  input  logic             reset,
  pmem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] word_idx;
  logic        in_range;
  logic        do_access;

  // Subtraction wraps, so addresses below the base need the explicit compare.
  assign word_idx  = (addr_q - ADDR_BASE) >> 2;
  assign in_range  = (addr_q >= ADDR_BASE) && (word_idx < 32'(DEPTH_WORDS));
  assign do_access = (state == WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      wen_q          <= 1'b0;
      addr_q         <= 32'd0;
      wdata_q        <= 32'd0;
      wmask_q        <= 4'd0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'd0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            wen_q         <= bus.req_wen;
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            wmask_q       <= bus.req_wmask;
            cnt           <= 4'(LATENCY - 1);
            bus.req_ready <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= !in_range;
            bus.resp_rdata <= (in_range && !wen_q) ? mem[word_idx[AW-1:0]] : 32'd0;
            state          <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'd0;
            bus.resp_err   <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end
        default: begin
          state          <= IDLE;
          bus.req_ready  <= 1'b1;
          bus.resp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Array has no reset; a write only lands on the WAIT->RESP edge.
  always_ff @(posedge clk) begin
    if (do_access && wen_q && in_range && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_q[i]) begin
          mem[word_idx[AW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - directed self-checking bench for pmem_responder at latencies 1, 3 and 4
module tb_pmem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid  [3];
  logic        req_wen    [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [3:0]  req_wmask  [3];
  logic        resp_ready [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Instance 0: LATENCY=1, instance 1: LATENCY=3, instance 2: LATENCY=4.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    pmem_responder_if bus ();
    assign bus.req_valid  = req_valid[g];
    assign bus.req_wen    = req_wen[g];
    assign bus.req_addr   = req_addr[g];
    assign bus.req_wdata  = req_wdata[g];
    assign bus.req_wmask  = req_wmask[g];
    assign bus.resp_ready = resp_ready[g];
    assign req_ready[g]   = bus.req_ready;
    assign resp_valid[g]  = bus.resp_valid;
    assign resp_rdata[g]  = bus.resp_rdata;
    assign resp_err[g]    = bus.resp_err;
    pmem_responder #(
      .ADDR_BASE  (32'h80000000),
      .DEPTH_WORDS(1024),
      .LATENCY    (LAT)
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );
  end

  task automatic do_txn(input int d, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    @(negedge clk);
    req_wen[d]    = wen;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_wmask[d]  = mask;
    req_valid[d]  = 1'b1;
    resp_ready[d] = 1'b1;
    guard = 0;
    while (!req_ready[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 0;
    while (!resp_valid[d] && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rdata = resp_rdata[d];
    err   = resp_err[d];
    if (!resp_valid[d]) lat = -1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if ({req_ready[d], resp_valid[d], resp_err[d], resp_rdata[d]} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got ready=%b valid=%b err=%b rdata=%h, expected ready=1 valid=0 err=0 rdata=00000000",
                 d, req_ready[d], resp_valid[d], resp_err[d], resp_rdata[d]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_write;
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_txn(0, 1'b1, 32'h80000010, 32'hDEADBEEF, 4'hF, rd, er, lat);
    n_tests++;
    if ({lat, er, rd} !== {32'd1, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL write_ack: got lat=%0d err=%b rdata=%h, expected lat=1 err=0 rdata=00000000", lat, er, rd);
    end
    do_txn(0, 1'b0, 32'h80000010, 32'h0, 4'h0, rd, er, lat);
    n_tests++;
    if ({lat, er, rd} !== {32'd1, 1'b0, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL write_readback: got lat=%0d err=%b rdata=%h, expected lat=1 err=0 rdata=deadbeef", lat, er, rd);
    end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_txn(0, 1'b1, 32'h80000010, 32'h000000AA, 4'h1, rd, er, lat);
    do_txn(0, 1'b0, 32'h80000010, 32'h0, 4'h0, rd, er, lat);
    n_tests++;
    if ({er, rd} !== {1'b0, 32'hDEADBEAA}) begin
      n_fail++;
      $display("FAIL lane0_write: got err=%b rdata=%h, expected err=0 rdata=deadbeaa", er, rd);
    end
    do_txn(0, 1'b1, 32'h80000010, 32'h12340000, 4'hC, rd, er, lat);
    do_txn(0, 1'b0, 32'h80000010, 32'h0, 4'h0, rd, er, lat);
    n_tests++;
    if ({er, rd} !== {1'b0, 32'h1234BEAA}) begin
      n_fail++;
      $display("FAIL lane32_write: got err=%b rdata=%h, expected err=0 rdata=1234beaa", er, rd);
    end
    // Zero-mask write is an acknowledged no-op.
    do_txn(0, 1'b1, 32'h80000010, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    n_tests++;
    if ({er, rd} !== {1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL nomask_ack: got err=%b rdata=%h, expected err=0 rdata=00000000", er, rd);
    end
    do_txn(0, 1'b0, 32'h80000010, 32'h0, 4'h0, rd, er, lat);
    n_tests++;
    if (rd !== 32'h1234BEAA) begin
      n_fail++;
      $display("FAIL nomask_readback: got rdata=%h, expected rdata=1234beaa", rd);
    end
  endtask

  task automatic test_latency;
    logic [31:0] rd;
    logic        er;
    int          lat;
    @(negedge clk);
    req_wen[1]    = 1'b1;
    req_addr[1]   = 32'h80000020;
    req_wdata[1]  = 32'h55AA33CC;
    req_wmask[1]  = 4'hF;
    req_valid[1]  = 1'b1;
    resp_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    for (int e = 0; e < 3; e++) begin
      n_tests++;
      if ({req_ready[1], resp_valid[1]} !== 2'b00) begin
        n_fail++;
        $display("FAIL lat3_wait edge k+%0d: got ready=%b valid=%b, expected ready=0 valid=0", e, req_ready[1], resp_valid[1]);
      end
      if (e < 2) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({req_ready[1], resp_valid[1], resp_err[1]} !== 3'b010) begin
      n_fail++;
      $display("FAIL lat3_resp edge k+3: got ready=%b valid=%b err=%b, expected ready=0 valid=1 err=0", req_ready[1], resp_valid[1], resp_err[1]);
    end
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({req_ready[1], resp_valid[1]} !== 2'b10) begin
      n_fail++;
      $display("FAIL lat3_after_handshake: got ready=%b valid=%b, expected ready=1 valid=0", req_ready[1], resp_valid[1]);
    end
    do_txn(1, 1'b0, 32'h80000020, 32'h0, 4'h0, rd, er, lat);
    n_tests++;
    if ({lat, er, rd} !== {32'd3, 1'b0, 32'h55AA33CC}) begin
      n_fail++;
      $display("FAIL lat3_read: got lat=%0d err=%b rdata=%h, expected lat=3 err=0 rdata=55aa33cc", lat, er, rd);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd;
    logic        er;
    int          lat;
    @(negedge clk);
    req_wen[0]    = 1'b0;
    req_addr[0]   = 32'h80000010;
    req_wmask[0]  = 4'h0;
    req_valid[0]  = 1'b1;
    resp_ready[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // A competing write stays asserted; it must not be taken while the response waits.
    req_wen[0]   = 1'b1;
    req_wdata[0] = 32'hFFFFFFFF;
    req_wmask[0] = 4'hF;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if ({resp_valid[0], req_ready[0], resp_err[0], resp_rdata[0]} !== {1'b1, 1'b0, 1'b0, 32'h1234BEAA}) begin
        n_fail++;
        $display("FAIL backpressure_hold cycle %0d: got valid=%b ready=%b err=%b rdata=%h, expected valid=1 ready=0 err=0 rdata=1234beaa",
                 c, resp_valid[0], req_ready[0], resp_err[0], resp_rdata[0]);
      end
      if (c < 4) @(posedge clk);
    end
    req_valid[0]  = 1'b0;
    resp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({req_ready[0], resp_valid[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL backpressure_release: got ready=%b valid=%b, expected ready=1 valid=0", req_ready[0], resp_valid[0]);
    end
    do_txn(0, 1'b0, 32'h80000010, 32'h0, 4'h0, rd, er, lat);
    n_tests++;
    if (rd !== 32'h1234BEAA) begin
      n_fail++;
      $display("FAIL backpressure_no_accept: got rdata=%h, expected rdata=1234beaa", rd);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_txn(0, 1'b1, 32'h80000000, 32'h11111111, 4'hF, rd, er, lat);
    do_txn(0, 1'b1, 32'h80000FFC, 32'h22222222, 4'hF, rd, er, lat);
    do_txn(0, 1'b0, 32'h7FFFFFFC, 32'h0, 4'h0, rd, er, lat);
    n_tests++;
    if ({er, rd} !== {1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL oor_below_base: got err=%b rdata=%h, expected err=1 rdata=00000000", er, rd);
    end
    do_txn(0, 1'b1, 32'h80001000, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    n_tests++;
    if ({er, rd} !== {1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL oor_write_end: got err=%b rdata=%h, expected err=1 rdata=00000000", er, rd);
    end
    do_txn(0, 1'b0, 32'h80000000, 32'h0, 4'h0, rd, er, lat);
    n_tests++;
    if ({er, rd} !== {1'b0, 32'h11111111}) begin
      n_fail++;
      $display("FAIL oor_word0_intact: got err=%b rdata=%h, expected err=0 rdata=11111111", er, rd);
    end
    do_txn(0, 1'b0, 32'h80000FFC, 32'h0, 4'h0, rd, er, lat);
    n_tests++;
    if ({er, rd} !== {1'b0, 32'h22222222}) begin
      n_fail++;
      $display("FAIL oor_last_intact: got err=%b rdata=%h, expected err=0 rdata=22222222", er, rd);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_txn(2, 1'b1, 32'h80000010, 32'h1234BEAA, 4'hF, rd, er, lat);
    n_tests++;
    if ({lat, er} !== {32'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL lat4_write: got lat=%0d err=%b, expected lat=4 err=0", lat, er);
    end
    @(negedge clk);
    req_wen[2]    = 1'b1;
    req_addr[2]   = 32'h80000010;
    req_wdata[2]  = 32'hCAFEF00D;
    req_wmask[2]  = 4'hF;
    req_valid[2]  = 1'b1;
    resp_ready[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if ({req_ready[2], resp_valid[2]} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_mid_state: got ready=%b valid=%b, expected ready=1 valid=0", req_ready[2], resp_valid[2]);
    end
    repeat (6) @(negedge clk);
    do_txn(2, 1'b0, 32'h80000010, 32'h0, 4'h0, rd, er, lat);
    n_tests++;
    if ({lat, er, rd} !== {32'd4, 1'b0, 32'h1234BEAA}) begin
      n_fail++;
      $display("FAIL reset_mid_dropped: got lat=%0d err=%b rdata=%h, expected lat=4 err=0 rdata=1234beaa", lat, er, rd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req_valid[d]  = 1'b0;
      req_wen[d]    = 1'b0;
      req_addr[d]   = 32'd0;
      req_wdata[d]  = 32'd0;
      req_wmask[d]  = 4'd0;
      resp_ready[d] = 1'b1;
    end
    test_reset();
    test_write();
    test_byte_lanes();
    test_latency();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
